// File: rtl/issue_pkg.sv
// Shared types for the multi-issue stage: the decoded entry carried through the
// issue queue to the execute lanes, plus register-file geometry.
package issue_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned NREGS       = 32;
    localparam int unsigned ENTRY_TAG_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]  rd;
        logic [REG_ADDR_W-1:0]  rs1;
        logic [REG_ADDR_W-1:0]  rs2;
        logic                   uses_rs1;
        logic                   uses_rs2;
        logic                   reg_write;
        logic                   is_mem;
        logic                   is_branch;
        logic [ENTRY_TAG_W-1:0] tag;
    } issue_entry_t;

endpackage

// File: rtl/issue_queue.sv
// Circular issue queue: up to ISSUE_W pushes and pops per cycle, exposes the
// ISSUE_W oldest entries with per-lane valids.
module issue_queue
    import issue_pkg::*;
#(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned QDEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [ISSUE_W-1:0]         push_valid,
    input  issue_entry_t [ISSUE_W-1:0] push_entry,
    input  logic [ISSUE_W-1:0]         pop_valid,
    output issue_entry_t [ISSUE_W-1:0] head_entry,
    output logic [ISSUE_W-1:0]         head_valid,
    output logic                       has_room
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    issue_entry_t     mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] n_push;
    logic [CNT_W-1:0] n_pop;

    always_comb begin
        n_push = '0;
        n_pop  = '0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            n_push = n_push + CNT_W'(push_valid[i]);
            n_pop  = n_pop + CNT_W'(pop_valid[i]);
        end
    end

    always_comb begin
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            head_entry[k] = mem_q[rd_ptr_q + PTR_W'(k)];
            head_valid[k] = count_q > CNT_W'(k);
        end
    end

    // Room for a full-width group, so the producer never has to split one.
    assign has_room = count_q <= CNT_W'(QDEPTH - ISSUE_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(n_pop);
            count_q  <= count_q + n_push - n_pop;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            if (push_valid[i]) begin
                mem_q[wr_ptr_q + PTR_W'(i)] <= push_entry[i];
            end
        end
    end

endmodule

// File: rtl/multi_issue_scoreboard.sv
// N-wide in-order issue stage: issue queue, per-group hazard checks against a
// register scoreboard, writeback clearing and a saturating stall counter.
module multi_issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned WB_W    = 2,
    parameter int unsigned QDEPTH  = 8,
    parameter int unsigned TAG_W   = ENTRY_TAG_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ISSUE_W-1:0]                  enq_valid,
    input  issue_entry_t [ISSUE_W-1:0]          enq_entry,
    output logic                                enq_ready,
    output logic [ISSUE_W-1:0]                  iss_valid,
    output issue_entry_t [ISSUE_W-1:0]          iss_entry,
    input  logic                                iss_ready,
    input  logic [WB_W-1:0]                     wb_valid,
    input  logic [WB_W-1:0][REG_ADDR_W-1:0]     wb_rd,
    input  logic                                flush,
    output logic [NREGS-1:0]                    busy_vec,
    output logic                                stall,
    output logic [31:0]                         stall_cycles
);

    logic [ISSUE_W-1:0] head_valid;
    logic [ISSUE_W-1:0] push_valid;
    logic               enq_fire;
    logic [NREGS-1:0]   busy_q;
    logic [NREGS-1:0]   busy_d;
    logic [31:0]        stall_q;
    logic [31:0]        stall_d;

    assign enq_fire   = enq_ready & (|enq_valid) & ~flush;
    assign push_valid = enq_valid & {ISSUE_W{enq_fire}};

    issue_queue #(
        .ISSUE_W (ISSUE_W),
        .QDEPTH  (QDEPTH)
    ) u_issue_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_entry (enq_entry),
        .pop_valid  (iss_valid),
        .head_entry (iss_entry),
        .head_valid (head_valid),
        .has_room   (enq_ready)
    );

    always_comb begin
        issue_entry_t cur;
        issue_entry_t old;
        logic         ok;
        logic         chain;
        iss_valid = '0;
        chain     = 1'b1;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            cur = iss_entry[k];
            ok  = head_valid[k] & iss_ready & ~flush;
            if (cur.uses_rs1 && busy_q[cur.rs1]) ok = 1'b0;
            if (cur.uses_rs2 && busy_q[cur.rs2]) ok = 1'b0;
            if (cur.reg_write && cur.rd != '0 && busy_q[cur.rd]) ok = 1'b0;
            // Intra-group hazards: older lanes in the same group are not yet in busy_q.
            for (int j = 0; j < k; j++) begin
                old = iss_entry[j];
                if (old.is_branch) ok = 1'b0;
                if (old.is_mem && cur.is_mem) ok = 1'b0;
                if (old.reg_write && old.rd != '0) begin
                    if ((cur.uses_rs1 && cur.rs1 == old.rd) ||
                        (cur.uses_rs2 && cur.rs2 == old.rd) ||
                        (cur.reg_write && cur.rd == old.rd)) begin
                        ok = 1'b0;
                    end
                end
            end
            chain        = chain & ok;
            iss_valid[k] = chain;
        end
    end

    // Clears first so a same-cycle issue of the same rd wins.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < int'(WB_W); p++) begin
            if (wb_valid[p]) busy_d[wb_rd[p]] = 1'b0;
        end
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            if (iss_valid[k] && iss_entry[k].reg_write && iss_entry[k].rd != '0) begin
                busy_d[iss_entry[k].rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    assign stall   = head_valid[0] & iss_ready & ~iss_valid[0];
    assign stall_d = (stall && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign busy_vec     = busy_q;
    assign stall_cycles = stall_q;

    logic [ISSUE_W-1:0] enq_valid_inc;
    assign enq_valid_inc = enq_valid + ISSUE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (TAG_W == ENTRY_TAG_W) else $error("TAG_W differs from issue_entry_t tag width");
        end else if (|enq_valid) begin
            assert (enq_ready) else $error("enqueue while enq_ready is low");
            assert ((enq_valid & enq_valid_inc) == '0) else $error("enq_valid not contiguous");
        end
    end

endmodule

// File: tb/tb_multi_issue_scoreboard.sv
// Directed bench for multi_issue_scoreboard: issued tags are checked in order
// against an expected-tag queue by a monitor; cycle behaviour checked inline.
module tb_multi_issue_scoreboard;
    import issue_pkg::*;

    localparam int unsigned ISSUE_W = 2;
    localparam int unsigned WB_W    = 2;
    localparam int unsigned QDEPTH  = 8;

    logic                            clk = 1'b0;
    logic                            reset;
    logic [ISSUE_W-1:0]              enq_valid;
    issue_entry_t [ISSUE_W-1:0]      enq_entry;
    logic                            enq_ready;
    logic [ISSUE_W-1:0]              iss_valid;
    issue_entry_t [ISSUE_W-1:0]      iss_entry;
    logic                            iss_ready;
    logic [WB_W-1:0]                 wb_valid;
    logic [WB_W-1:0][REG_ADDR_W-1:0] wb_rd;
    logic                            flush;
    logic [NREGS-1:0]                busy_vec;
    logic                            stall;
    logic [31:0]                     stall_cycles;

    int                     tests = 0;
    int                     fails = 0;
    logic [ENTRY_TAG_W-1:0] exp_q[$];
    logic [ENTRY_TAG_W-1:0] exp_tag;
    logic [31:0]            exp_stall;

    always #5 clk = ~clk;

    multi_issue_scoreboard #(
        .ISSUE_W (ISSUE_W),
        .WB_W    (WB_W),
        .QDEPTH  (QDEPTH),
        .TAG_W   (ENTRY_TAG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enq_valid    (enq_valid),
        .enq_entry    (enq_entry),
        .enq_ready    (enq_ready),
        .iss_valid    (iss_valid),
        .iss_entry    (iss_entry),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic issue_entry_t alu(input int rd, input int rs1, input int rs2, input int tag);
        issue_entry_t e;
        e           = '0;
        e.rd        = REG_ADDR_W'(rd);
        e.rs1       = REG_ADDR_W'(rs1);
        e.rs2       = REG_ADDR_W'(rs2);
        e.uses_rs1  = 1'b1;
        e.uses_rs2  = 1'b1;
        e.reg_write = 1'b1;
        e.tag       = ENTRY_TAG_W'(tag);
        return e;
    endfunction

    function automatic issue_entry_t ld(input int rd, input int rs1, input int tag);
        issue_entry_t e;
        e           = '0;
        e.rd        = REG_ADDR_W'(rd);
        e.rs1       = REG_ADDR_W'(rs1);
        e.uses_rs1  = 1'b1;
        e.reg_write = 1'b1;
        e.is_mem    = 1'b1;
        e.tag       = ENTRY_TAG_W'(tag);
        return e;
    endfunction

    function automatic issue_entry_t beq(input int rs1, input int rs2, input int tag);
        issue_entry_t e;
        e           = '0;
        e.rs1       = REG_ADDR_W'(rs1);
        e.rs2       = REG_ADDR_W'(rs2);
        e.uses_rs1  = 1'b1;
        e.uses_rs2  = 1'b1;
        e.is_branch = 1'b1;
        e.tag       = ENTRY_TAG_W'(tag);
        return e;
    endfunction

    function automatic issue_entry_t nop(input int tag);
        issue_entry_t e;
        e     = '0;
        e.tag = ENTRY_TAG_W'(tag);
        return e;
    endfunction

    task automatic enq2(input issue_entry_t a, input issue_entry_t b);
        enq_valid    = 2'b11;
        enq_entry[0] = a;
        enq_entry[1] = b;
        exp_q.push_back(a.tag);
        exp_q.push_back(b.tag);
        step();
        enq_valid = '0;
    endtask

    task automatic wb(input logic [1:0] v, input int r0, input int r1);
        wb_valid = v;
        wb_rd[0] = REG_ADDR_W'(r0);
        wb_rd[1] = REG_ADDR_W'(r1);
    endtask

    // Monitor: every accepted issued lane must carry the next expected tag.
    always @(negedge clk) begin
        if (!reset && iss_ready) begin
            for (int k = 0; k < int'(ISSUE_W); k++) begin
                if (iss_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL issue_order: lane %0d issued tag %0h, expected no issue",
                                 k, iss_entry[k].tag);
                    end else begin
                        exp_tag = exp_q.pop_front();
                        check("issue_order", 32'(iss_entry[k].tag), 32'(exp_tag));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        enq_valid = '0;
        enq_entry = '0;
        iss_ready = 1'b0;
        wb_valid  = '0;
        wb_rd     = '0;
        flush     = 1'b0;
        exp_stall = 0;

        // Reset state
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t1_enq_ready", 32'(enq_ready), 1);
        check("t1_iss_valid", 32'(iss_valid), 0);
        check("t1_busy", busy_vec, 0);
        check("t1_stall_cycles", stall_cycles, 0);
        check("t1_stall", 32'(stall), 0);

        // Independent pair issues together, then both rd bits become busy
        iss_ready = 1'b1;
        enq2(alu(1, 2, 3, 8'h01), alu(4, 5, 6, 8'h02));
        @(negedge clk);
        check("t2_iss_valid", 32'(iss_valid), 32'b11);
        step();
        @(negedge clk);
        check("t2_busy", busy_vec, 32'h0000_0012);
        wb(2'b11, 1, 4);
        step();
        wb_valid = '0;
        @(negedge clk);
        check("t2_busy_clr", busy_vec, 0);

        // RAW inside group, then across cycles until writeback
        enq2(alu(1, 2, 3, 8'h03), alu(7, 1, 2, 8'h04));
        @(negedge clk);
        check("t3_iss_lane0", 32'(iss_valid), 32'b01);
        step();
        @(negedge clk);
        check("t3_iss_hold", 32'(iss_valid), 0);
        check("t3_stall_a", 32'(stall), 1);
        step();
        @(negedge clk);
        check("t3_stall_b", 32'(stall), 1);
        check("t3_stall_cnt1", stall_cycles, 1);
        wb(2'b01, 1, 0);
        step();
        wb_valid = '0;
        @(negedge clk);
        check("t3_iss_after_wb", 32'(iss_valid), 32'b01);
        check("t3_stall_clr", 32'(stall), 0);
        exp_stall = 2;
        check("t3_stall_cnt2", stall_cycles, exp_stall);
        step();
        @(negedge clk);
        check("t3_busy7", busy_vec, 32'h0000_0080);
        wb(2'b01, 7, 0);
        step();
        wb_valid = '0;

        // One memory op per group; a branch ends the group
        enq2(ld(8, 2, 8'h05), ld(9, 2, 8'h06));
        @(negedge clk);
        check("t4_ld_first", 32'(iss_valid), 32'b01);
        step();
        @(negedge clk);
        check("t4_ld_second", 32'(iss_valid), 32'b01);
        step();
        @(negedge clk);
        check("t4_busy_ld", busy_vec, 32'h0000_0300);
        wb(2'b11, 8, 9);
        step();
        wb_valid = '0;
        enq2(beq(2, 3, 8'h07), alu(10, 2, 3, 8'h08));
        @(negedge clk);
        check("t4_beq_alone", 32'(iss_valid), 32'b01);
        step();
        @(negedge clk);
        check("t4_add_next", 32'(iss_valid), 32'b01);
        step();
        wb(2'b01, 10, 0);
        step();
        wb_valid = '0;

        // Flush keeps busy bits; same-cycle set beats clear
        enq2(alu(11, 2, 3, 8'h09), nop(8'h0A));
        @(negedge clk);
        check("t5_pre_iss", 32'(iss_valid), 32'b11);
        step();
        iss_ready = 1'b0;
        for (int g = 0; g < 3; g++) enq2(nop(8'h20 + 2 * g), nop(8'h21 + 2 * g));
        @(negedge clk);
        check("t5_ready_6", 32'(enq_ready), 1);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush     = 1'b0;
        iss_ready = 1'b1;
        @(negedge clk);
        check("t5_flush_iss", 32'(iss_valid), 0);
        check("t5_flush_ready", 32'(enq_ready), 1);
        check("t5_flush_busy", busy_vec, 32'h0000_0800);
        enq2(alu(1, 2, 3, 8'h30), nop(8'h31));
        wb(2'b11, 1, 11);
        @(negedge clk);
        check("t5_setwin_iss", 32'(iss_valid), 32'b11);
        step();
        wb_valid = '0;
        @(negedge clk);
        check("t5_setwin_busy", busy_vec, 32'h0000_0002);
        wb(2'b01, 1, 0);
        step();
        wb_valid = '0;

        // Fill the queue with execute back-pressured, then drain oldest-first
        iss_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check("t6_ready_fill", 32'(enq_ready), 1);
            enq2(nop(8'h40 + 2 * g), nop(8'h41 + 2 * g));
        end
        @(negedge clk);
        check("t6_full", 32'(enq_ready), 0);
        check("t6_no_stall", stall_cycles, exp_stall);
        step();
        iss_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_drain", 32'(iss_valid), 32'b11);
            step();
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("t6_drained", 32'(exp_q.size()), 0);
        @(negedge clk);
        check("t6_ready_again", 32'(enq_ready), 1);

        // Reset mid-operation, writeback during reset ignored
        enq2(alu(5, 0, 0, 8'h50), nop(8'h51));
        step();
        @(negedge clk);
        check("t7_busy5", busy_vec, 32'h0000_0020);
        iss_ready = 1'b0;
        enq2(nop(8'h52), nop(8'h53));
        reset = 1'b1;
        wb(2'b01, 5, 0);
        exp_q.delete();
        step();
        reset     = 1'b0;
        wb_valid  = '0;
        iss_ready = 1'b1;
        @(negedge clk);
        check("t7_busy", busy_vec, 0);
        check("t7_enq_ready", 32'(enq_ready), 1);
        check("t7_iss_valid", 32'(iss_valid), 0);
        check("t7_stall_cycles", stall_cycles, 0);
        check("t7_stall", 32'(stall), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
